// File: rtl/cbb_barrel_shifter_pkg.sv
// cbb_pkg: shared definitions for the common-building-block shifter family.
//   clog2      - ceiling log2, used to size the mux network at elaboration
//   DIR_LEFT   - shift towards the MSB
//   DIR_RIGHT  - shift towards the LSB
package cbb_pkg;

   localparam int unsigned DIR_LEFT  = 0;
   localparam int unsigned DIR_RIGHT = 1;

   function automatic int unsigned clog2(input int unsigned value);
      int unsigned result;
      result = 0;
      for (int unsigned i = 0; i < 32; i++) begin
         if ((64'd1 << i) < 64'(value)) result = i + 1;
      end
      return result;
   endfunction

endpackage

// File: rtl/cbb_barrel_shifter_if.sv
// cbb_barrel_shifter_if: request/result bundle of the barrel shifter.
//   in_valid      - data_in/shift_amount are sampled this cycle
//   data_in       - word to shift (W bits)
//   shift_amount  - unsigned shift distance (SHIFT_W bits)
//   out_valid     - data_out holds a new result
//   data_out      - registered shifted/rotated word (W bits)
// master drives the request side, slave is the shifter.
interface cbb_barrel_shifter_if #(
   parameter int unsigned W       = 8,
   parameter int unsigned SHIFT_W = 32
);
   logic               in_valid;
   logic [W-1:0]       data_in;
   logic [SHIFT_W-1:0] shift_amount;
   logic               out_valid;
   logic [W-1:0]       data_out;

   modport master (
      output in_valid, data_in, shift_amount,
      input  out_valid, data_out
   );

   modport slave (
      input  in_valid, data_in, shift_amount,
      output out_valid, data_out
   );
endinterface

// File: rtl/cbb_barrel_shifter_stage.sv
// cbb_barrel_stage: one level of the barrel shifter mux network.
//   sel  - when high, dout is din moved by SHIFT positions; else dout = din
//   din  - stage input word
//   dout - stage output word
// DIR selects left/right; ROTATE selects circular wrap versus zero fill.
module cbb_barrel_stage
   import cbb_pkg::*;
#(
   parameter int unsigned W      = 8,
   parameter int unsigned SHIFT  = 1,
   parameter int unsigned DIR    = DIR_LEFT,
   parameter int unsigned ROTATE = 1
) (
   input  logic         sel,
   input  logic [W-1:0] din,
   output logic [W-1:0] dout
);

   logic [W-1:0] moved;

   generate
      if (DIR == DIR_LEFT) begin : g_left
         if (ROTATE != 0) begin : g_rot
            assign moved = (din << SHIFT) | (din >> (W - SHIFT));
         end else begin : g_log
            assign moved = din << SHIFT;
         end
      end else begin : g_right
         if (ROTATE != 0) begin : g_rot
            assign moved = (din >> SHIFT) | (din << (W - SHIFT));
         end else begin : g_log
            assign moved = din >> SHIFT;
         end
      end
   endgenerate

   always_comb begin
      dout = din;
      if (sel) dout = moved;
   end

endmodule

// File: rtl/cbb_barrel_shifter.sv
// cbb_barrel_shifter: single-cycle variable rotate / logical shift.
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset (clears data_out and out_valid)
//   bus  - slave side of cbb_barrel_shifter_if (in_valid, data_in,
//          shift_amount in; out_valid, data_out out)
// log2(W) cascaded mux stages feed one output register; latency 1 cycle.
module cbb_barrel_shifter
   import cbb_pkg::*;
#(
   parameter int unsigned W       = 8,
   parameter int unsigned SHIFT_W = 32,
   parameter int unsigned DIR     = DIR_LEFT,
   parameter int unsigned ROTATE  = 1
) (
   input logic                 clk,
   input logic                 rst,
   cbb_barrel_shifter_if.slave bus
);

   localparam int unsigned S = clog2(W);

   generate
      if (W < 2 || W > 1024 || (W & (W - 1)) != 0) begin : g_bad_w
         $error("cbb_barrel_shifter: W must be a power of two in 2..1024");
      end
      if (SHIFT_W < 1) begin : g_bad_sw
         $error("cbb_barrel_shifter: SHIFT_W must be at least 1");
      end
      if (DIR > 1 || ROTATE > 1) begin : g_bad_mode
         $error("cbb_barrel_shifter: DIR and ROTATE must be 0 or 1");
      end
   endgenerate

   logic [S-1:0] amt;
   logic         over;
   logic [W-1:0] stage_data [0:S];
   logic [W-1:0] next_data;
   logic [W-1:0] data_q;
   logic         valid_q;

   // Low S bits are the mod-W amount; narrow shift_amount is zero-extended.
   generate
      for (genvar k = 0; k < S; k++) begin : g_amt
         if (k < SHIFT_W) begin : g_bit
            assign amt[k] = bus.shift_amount[k];
         end else begin : g_pad
            assign amt[k] = 1'b0;
         end
      end
      if (SHIFT_W > S) begin : g_over
         assign over = |bus.shift_amount[SHIFT_W-1:S];
      end else begin : g_no_over
         assign over = 1'b0;
      end
   endgenerate

   assign stage_data[0] = bus.data_in;

   generate
      for (genvar k = 0; k < S; k++) begin : g_stage
         cbb_barrel_stage #(
            .W      (W),
            .SHIFT  (1 << k),
            .DIR    (DIR),
            .ROTATE (ROTATE)
         ) u_stage (
            .sel  (amt[k]),
            .din  (stage_data[k]),
            .dout (stage_data[k+1])
         );
      end
   endgenerate

   // Logical mode: any amount >= W clears the word entirely.
   always_comb begin
      next_data = stage_data[S];
      if (ROTATE == 0 && over) next_data = '0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         data_q  <= '0;
         valid_q <= 1'b0;
      end else begin
         valid_q <= bus.in_valid;
         if (bus.in_valid) data_q <= next_data;
      end
   end

   assign bus.data_out  = data_q;
   assign bus.out_valid = valid_q;

endmodule

// File: tb/tb_cbb_barrel_shifter.sv
// Bench for cbb_barrel_shifter: four instances (left/right x rotate/logical)
// share one stimulus stream; a queue holds the expected word of every
// instance per accepted sample and is popped when the result is due.
module tb_cbb_barrel_shifter;

   logic clk;
   logic rst;
   logic        in_valid_s;
   logic [7:0]  data_s;
   logic [31:0] amt_s;

   logic [3:0][7:0] dout_all;
   logic [3:0]      ov_all;
   logic [3:0][7:0] sb_q [$];

   int checks;
   int passed;

   cbb_barrel_shifter_if #(.W(8), .SHIFT_W(32)) if0 ();
   cbb_barrel_shifter_if #(.W(8), .SHIFT_W(32)) if1 ();
   cbb_barrel_shifter_if #(.W(8), .SHIFT_W(32)) if2 ();
   cbb_barrel_shifter_if #(.W(8), .SHIFT_W(32)) if3 ();

   cbb_barrel_shifter #(.W(8), .SHIFT_W(32), .DIR(0), .ROTATE(1))
      u_lrot (.clk(clk), .rst(rst), .bus(if0));
   cbb_barrel_shifter #(.W(8), .SHIFT_W(32), .DIR(0), .ROTATE(0))
      u_llog (.clk(clk), .rst(rst), .bus(if1));
   cbb_barrel_shifter #(.W(8), .SHIFT_W(32), .DIR(1), .ROTATE(1))
      u_rrot (.clk(clk), .rst(rst), .bus(if2));
   cbb_barrel_shifter #(.W(8), .SHIFT_W(32), .DIR(1), .ROTATE(0))
      u_rlog (.clk(clk), .rst(rst), .bus(if3));

   assign if0.in_valid = in_valid_s;
   assign if1.in_valid = in_valid_s;
   assign if2.in_valid = in_valid_s;
   assign if3.in_valid = in_valid_s;
   assign if0.data_in = data_s;
   assign if1.data_in = data_s;
   assign if2.data_in = data_s;
   assign if3.data_in = data_s;
   assign if0.shift_amount = amt_s;
   assign if1.shift_amount = amt_s;
   assign if2.shift_amount = amt_s;
   assign if3.shift_amount = amt_s;

   assign dout_all[0] = if0.data_out;
   assign dout_all[1] = if1.data_out;
   assign dout_all[2] = if2.data_out;
   assign dout_all[3] = if3.data_out;
   assign ov_all[0] = if0.out_valid;
   assign ov_all[1] = if1.out_valid;
   assign ov_all[2] = if2.out_valid;
   assign ov_all[3] = if3.out_valid;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Bit-placement reference model: each source bit moved individually.
   function automatic logic [7:0] model(input logic [7:0] x, input logic [31:0] amount,
                                        input bit right, input bit rot);
      logic [7:0] r;
      int a;
      r = '0;
      if (rot) a = int'(amount % 32'd8);
      else if (amount >= 32'd8) return 8'h00;
      else a = int'(amount);
      for (int i = 0; i < 8; i++) begin
         if (!right) begin
            if (rot) r[(i + a) % 8] = x[i];
            else if (i + a < 8) r[i + a] = x[i];
         end else begin
            if (rot) r[(i + 8 - a) % 8] = x[i];
            else if (i >= a) r[i - a] = x[i];
         end
      end
      return r;
   endfunction

   function automatic logic [3:0][7:0] model_all(input logic [7:0] x, input logic [31:0] amount);
      logic [3:0][7:0] r;
      r[0] = model(x, amount, 1'b0, 1'b1);
      r[1] = model(x, amount, 1'b0, 1'b0);
      r[2] = model(x, amount, 1'b1, 1'b1);
      r[3] = model(x, amount, 1'b1, 1'b0);
      return r;
   endfunction

   task automatic drive(input logic v, input logic [7:0] d, input logic [31:0] a);
      in_valid_s = v;
      data_s     = d;
      amt_s      = a;
      if (v) sb_q.push_back(model_all(d, a));
   endtask

   // rst and in_valid asserted at the same edge: reset wins.
   task automatic test_reset(input string tag);
      @(negedge clk);
      rst = 1'b1;
      in_valid_s = 1'b1;
      data_s = 8'hFF;
      amt_s = 32'd1;
      @(negedge clk);
      for (int d = 0; d < 4; d++) begin
         checks++;
         if (dout_all[d] !== 8'h00 || ov_all[d] !== 1'b0)
            $display("FAIL %s dut%0d: data_out=%h out_valid=%b, required 00/0",
                     tag, d, dout_all[d], ov_all[d]);
         else passed++;
      end
      in_valid_s = 1'b0;
      rst = 1'b0;
   endtask

   task automatic test_rotate_left();
      logic [7:0]  din [6]  = '{8'hAA, 8'hF0, 8'h0F, 8'h81, 8'hB1, 8'hB1};
      logic [31:0] amt [6]  = '{32'd3, 32'd4, 32'd5, 32'd7, 32'd8, 32'd11};
      logic [7:0]  want [6] = '{8'h55, 8'h0F, 8'hE1, 8'hC0, 8'hB1, 8'h8D};
      logic [3:0][7:0] e;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         drive(1'b1, din[i], amt[i]);
         @(negedge clk);
         e = sb_q.pop_front();
         drive(1'b0, 8'h00, 32'd0);
         checks++;
         if (dout_all[0] !== want[i] || ov_all[0] !== 1'b1)
            $display("FAIL rotl_const %h<<%0d: got %h/%b, required %h/1",
                     din[i], amt[i], dout_all[0], ov_all[0], want[i]);
         else passed++;
         for (int d = 1; d < 4; d++) begin
            checks++;
            if (dout_all[d] !== e[d] || ov_all[d] !== 1'b1)
               $display("FAIL rotl_model dut%0d %h,%0d: got %h/%b, required %h/1",
                        d, din[i], amt[i], dout_all[d], ov_all[d], e[d]);
            else passed++;
         end
      end
   endtask

   task automatic test_logical_left();
      logic [31:0] amt [3]  = '{32'd2, 32'd8, 32'h8000_0001};
      logic [7:0]  want [3] = '{8'hC0, 8'h00, 8'h00};
      logic [3:0][7:0] e;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         drive(1'b1, 8'hF0, amt[i]);
         @(negedge clk);
         e = sb_q.pop_front();
         drive(1'b0, 8'h00, 32'd0);
         checks++;
         if (dout_all[1] !== want[i] || ov_all[1] !== 1'b1)
            $display("FAIL lsl_const F0<<%h: got %h/%b, required %h/1",
                     amt[i], dout_all[1], ov_all[1], want[i]);
         else passed++;
         checks++;
         if (dout_all[3] !== e[3])
            $display("FAIL lsr_model F0>>%h: got %h, required %h", amt[i], dout_all[3], e[3]);
         else passed++;
      end
   endtask

   task automatic test_right_dir();
      logic [3:0][7:0] e;
      @(negedge clk);
      drive(1'b1, 8'h03, 32'd1);
      @(negedge clk);
      e = sb_q.pop_front();
      drive(1'b0, 8'h00, 32'd0);
      checks++;
      if (dout_all[2] !== 8'h81 || ov_all[2] !== 1'b1)
         $display("FAIL rotr 03>>1: got %h/%b, required 81/1", dout_all[2], ov_all[2]);
      else passed++;
      checks++;
      if (dout_all[3] !== 8'h01 || ov_all[3] !== 1'b1)
         $display("FAIL lsr 03>>1: got %h/%b, required 01/1", dout_all[3], ov_all[3]);
      else passed++;
      checks++;
      if (dout_all[0] !== e[0] || dout_all[1] !== e[1])
         $display("FAIL left_model 03,1: got %h %h, required %h %h",
                  dout_all[0], dout_all[1], e[0], e[1]);
      else passed++;
   endtask

   // After reset release with in_valid low: out_valid 0 and data_out held.
   task automatic test_hold();
      logic [3:0][7:0] last;
      @(negedge clk);
      for (int d = 0; d < 4; d++) begin
         checks++;
         if (dout_all[d] !== 8'h00 || ov_all[d] !== 1'b0)
            $display("FAIL idle_after_rst dut%0d: got %h/%b, required 00/0",
                     d, dout_all[d], ov_all[d]);
         else passed++;
      end
      drive(1'b1, 8'h5A, 32'd3);
      @(negedge clk);
      last = sb_q.pop_front();
      drive(1'b0, 8'hFF, 32'd5);
      for (int d = 0; d < 4; d++) begin
         checks++;
         if (dout_all[d] !== last[d] || ov_all[d] !== 1'b1)
            $display("FAIL hold_load dut%0d: got %h/%b, required %h/1",
                     d, dout_all[d], ov_all[d], last[d]);
         else passed++;
      end
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         for (int d = 0; d < 4; d++) begin
            checks++;
            if (dout_all[d] !== last[d] || ov_all[d] !== 1'b0)
               $display("FAIL hold dut%0d cyc%0d: got %h/%b, required %h/0",
                        d, c, dout_all[d], ov_all[d], last[d]);
            else passed++;
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [3:0][7:0] e;
      logic [31:0] a;
      for (int i = 0; i <= 16; i++) begin
         @(negedge clk);
         if (i > 0) begin
            e = sb_q.pop_front();
            for (int d = 0; d < 4; d++) begin
               checks++;
               if (dout_all[d] !== e[d] || ov_all[d] !== 1'b1)
                  $display("FAIL b2b dut%0d item%0d: got %h/%b, required %h/1",
                           d, i - 1, dout_all[d], ov_all[d], e[d]);
               else passed++;
            end
         end
         if (i < 16) begin
            a = (i % 4 == 3) ? $urandom() : 32'($urandom_range(0, 9));
            drive(1'b1, 8'($urandom()), a);
         end else begin
            drive(1'b0, 8'h00, 32'd0);
         end
      end
   endtask

   initial begin
      checks = 0;
      passed = 0;
      rst = 1'b1;
      in_valid_s = 1'b0;
      data_s = 8'h00;
      amt_s = 32'd0;
      test_reset("reset_start");
      test_hold();
      test_rotate_left();
      test_logical_left();
      test_right_dir();
      test_back_to_back();
      @(negedge clk);
      drive(1'b1, 8'hC3, 32'd2);
      sb_q.delete();
      test_reset("reset_with_valid");
      checks++;
      if (sb_q.size() !== 0)
         $display("FAIL scoreboard_drain: %0d entries left, required 0", sb_q.size());
      else passed++;
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
